// File: rtl/ipa_cfg_arbiter.sv
// Round-robin arbiter sharing one IPA config slave port between NUM_MASTERS requesters.
// Optional response timeout with sticky timeout_err port: define IPA_CFG_ARB_TIMEOUT_EN.
module ipa_cfg_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BE_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_cfg_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_cfg_add,
    input  logic [NUM_MASTERS-1:0]            m_cfg_wen,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_cfg_wdata,
    input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_cfg_be,
    input  logic [NUM_MASTERS*5-1:0]          m_cfg_id,
    output logic [NUM_MASTERS-1:0]            m_cfg_gnt,
    output logic [DATA_WIDTH-1:0]             m_cfg_rdata,
    output logic [NUM_MASTERS-1:0]            m_cfg_valid,
    output logic [4:0]                        m_cfg_r_id,
    output logic                              s_cfg_req,
    output logic [ADDR_WIDTH-1:0]             s_cfg_add,
    output logic                              s_cfg_wen,
    output logic [DATA_WIDTH-1:0]             s_cfg_wdata,
    output logic [BE_WIDTH-1:0]               s_cfg_be,
    output logic [4:0]                        s_cfg_id,
    input  logic                              s_cfg_gnt,
    input  logic [DATA_WIDTH-1:0]             s_cfg_rdata,
    input  logic                              s_cfg_valid,
    output logic                              busy
`ifdef IPA_CFG_ARB_TIMEOUT_EN
    ,
    output logic                              timeout_err
`endif
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ipa_cfg_arbiter: unsupported parameter value");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic [ADDR_WIDTH-1:0]   add_q, add_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic [4:0]              id_q, id_d;

    logic [IDX_W-1:0]        pick;
    logic                    pick_vld;
    int unsigned             cand;
    logic [ADDR_WIDTH-1:0]   sel_add;
    logic                    sel_wen;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [BE_WIDTH-1:0]     sel_be;
    logic [4:0]              sel_id;

    logic [NUM_MASTERS-1:0]  gnt;
    logic                    sreq;
    logic                    done;
    logic                    tmo;

`ifdef IPA_CFG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    // First requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = 0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_MASTERS;
            if (!pick_vld && m_cfg_req[IDX_W'(cand)]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        sel_add   = '0;
        sel_wen   = 1'b0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_id    = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (IDX_W'(i) == pick) begin
                sel_add   = m_cfg_add[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wen   = m_cfg_wen[i];
                sel_wdata = m_cfg_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_be    = m_cfg_be[i*BE_WIDTH +: BE_WIDTH];
                sel_id    = m_cfg_id[i*5 +: 5];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        add_d    = add_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        id_d     = id_q;
        gnt      = '0;
        sreq     = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
`ifdef IPA_CFG_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        terr_d   = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt     = NUM_MASTERS'(1) << pick;
                    win_d   = pick;
                    add_d   = sel_add;
                    wen_d   = sel_wen;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    id_d    = sel_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sreq = 1'b1;
                if (s_cfg_gnt) begin
                    if (s_cfg_valid) begin
                        done = 1'b1;
                    end else begin
                        state_d = RESP;
`ifdef IPA_CFG_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            RESP: begin
                if (s_cfg_valid) begin
                    done = 1'b1;
                end
`ifdef IPA_CFG_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    done   = 1'b1;
                    tmo    = 1'b1;
                    terr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d  = IDLE;
            rr_ptr_d = (win_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            add_q    <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            id_q     <= '0;
`ifdef IPA_CFG_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            add_q    <= add_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            id_q     <= id_d;
`ifdef IPA_CFG_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
`endif
        end
    end

    // Every output is held at zero while reset is asserted, regardless of register state.
    assign m_cfg_gnt   = rst_n ? gnt : '0;
    assign m_cfg_valid = (rst_n && done) ? (NUM_MASTERS'(1) << win_q) : '0;
    assign m_cfg_rdata = (rst_n && done) ? (tmo ? DATA_WIDTH'(32'hDEAD_BEEF) : s_cfg_rdata) : '0;
    assign m_cfg_r_id  = (rst_n && done) ? id_q : '0;
    assign s_cfg_req   = rst_n & sreq;
    assign s_cfg_add   = rst_n ? add_q : '0;
    assign s_cfg_wen   = rst_n & wen_q;
    assign s_cfg_wdata = rst_n ? wdata_q : '0;
    assign s_cfg_be    = rst_n ? be_q : '0;
    assign s_cfg_id    = rst_n ? id_q : '0;
    assign busy        = rst_n && (state_q != IDLE);
`ifdef IPA_CFG_ARB_TIMEOUT_EN
    assign timeout_err = rst_n & terr_q;
`endif

endmodule

// File: tb/tb_ipa_cfg_arbiter.sv
// Self-checking bench for ipa_cfg_arbiter: transaction-level model plus directed scenarios.
// Timeout scenario is built only when IPA_CFG_ARB_TIMEOUT_EN is defined.
module tb_ipa_cfg_arbiter;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     m_cfg_req = '0;
    logic [NM*AW-1:0]  m_cfg_add = '0;
    logic [NM-1:0]     m_cfg_wen = '0;
    logic [NM*DW-1:0]  m_cfg_wdata = '0;
    logic [NM*BW-1:0]  m_cfg_be = '0;
    logic [NM*5-1:0]   m_cfg_id = '0;
    logic [NM-1:0]     m_cfg_gnt;
    logic [DW-1:0]     m_cfg_rdata;
    logic [NM-1:0]     m_cfg_valid;
    logic [4:0]        m_cfg_r_id;
    logic              s_cfg_req;
    logic [AW-1:0]     s_cfg_add;
    logic              s_cfg_wen;
    logic [DW-1:0]     s_cfg_wdata;
    logic [BW-1:0]     s_cfg_be;
    logic [4:0]        s_cfg_id;
    logic              s_cfg_gnt = 1'b0;
    logic [DW-1:0]     s_cfg_rdata = '0;
    logic              s_cfg_valid = 1'b0;
    logic              busy;
`ifdef IPA_CFG_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    ipa_cfg_arbiter #(
        .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cfg_req(m_cfg_req), .m_cfg_add(m_cfg_add), .m_cfg_wen(m_cfg_wen),
        .m_cfg_wdata(m_cfg_wdata), .m_cfg_be(m_cfg_be), .m_cfg_id(m_cfg_id),
        .m_cfg_gnt(m_cfg_gnt), .m_cfg_rdata(m_cfg_rdata), .m_cfg_valid(m_cfg_valid),
        .m_cfg_r_id(m_cfg_r_id),
        .s_cfg_req(s_cfg_req), .s_cfg_add(s_cfg_add), .s_cfg_wen(s_cfg_wen),
        .s_cfg_wdata(s_cfg_wdata), .s_cfg_be(s_cfg_be), .s_cfg_id(s_cfg_id),
        .s_cfg_gnt(s_cfg_gnt), .s_cfg_rdata(s_cfg_rdata), .s_cfg_valid(s_cfg_valid),
        .busy(busy)
`ifdef IPA_CFG_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [31:0] add, input logic wen,
                         input logic [31:0] wd, input logic [4:0] id);
        m_cfg_add[i*AW +: AW]   = add;
        m_cfg_wen[i]            = wen;
        m_cfg_wdata[i*DW +: DW] = wd;
        m_cfg_be[i*BW +: BW]    = 4'hF;
        m_cfg_id[i*5 +: 5]      = id;
    endtask

    // Slave: auto mode grants always and answers one cycle after each handshake.
    logic          slv_auto = 1'b1;
    logic          man_gnt = 1'b0;
    logic          man_valid = 1'b0;
    logic [DW-1:0] man_rdata = '0;
    logic          hs = 1'b0;
    logic [DW-1:0] hs_rd = '0;

    always @(negedge clk) begin
        hs    = s_cfg_req & s_cfg_gnt;
        hs_rd = 32'h5000_0000 + {19'd0, s_cfg_id, 8'd0} + {24'd0, s_cfg_add[7:0]};
    end

    always @(posedge clk) begin
        #2;
        if (slv_auto) begin
            s_cfg_gnt   = 1'b1;
            s_cfg_valid = hs;
            s_cfg_rdata = hs ? hs_rd : '0;
        end else begin
            s_cfg_gnt   = man_gnt;
            s_cfg_valid = man_valid;
            s_cfg_rdata = man_rdata;
        end
    end

    function automatic int pick_rr(input logic [NM-1:0] req, input int ptr);
        for (int k = 0; k < NM; k++) begin
            if (req[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return 0;
    endfunction

    // Model: one outstanding transaction record, "sent" once the slave has accepted it.
    bit            mb_busy = 0;
    bit            mb_sent = 0;
    int            mb_ptr = 0;
    int            mb_win = 0;
    int            mb_wait = 0;
    bit            mb_terr = 0;
    logic [AW-1:0] mb_add;
    logic          mb_wen;
    logic [DW-1:0] mb_wdata;
    logic [BW-1:0] mb_be;
    logic [4:0]    mb_id;

    int gq[$];
    int vq[$];
    int rq[$];

    always @(negedge clk) begin
        logic [NM-1:0] e_gnt, e_val;
        logic [DW-1:0] e_rd;
        logic [4:0]    e_rid;
        logic          e_sreq, e_busy, e_terr, fin, timed;
        int            w;
        e_gnt = '0; e_val = '0; e_rd = '0; e_rid = '0;
        e_sreq = 0; e_busy = 0; fin = 0; timed = 0;
        e_terr = rst_n & mb_terr;
        if (!rst_n) begin
            mb_busy = 0; mb_sent = 0; mb_ptr = 0; mb_wait = 0; mb_terr = 0;
        end else if (!mb_busy) begin
            if (|m_cfg_req) begin
                w        = pick_rr(m_cfg_req, mb_ptr);
                e_gnt    = NM'(1) << w;
                mb_win   = w;
                mb_add   = m_cfg_add[w*AW +: AW];
                mb_wen   = m_cfg_wen[w];
                mb_wdata = m_cfg_wdata[w*DW +: DW];
                mb_be    = m_cfg_be[w*BW +: BW];
                mb_id    = m_cfg_id[w*5 +: 5];
                mb_busy  = 1;
                mb_sent  = 0;
            end
        end else begin
            e_busy = 1;
            if (!mb_sent) begin
                e_sreq = 1;
                if (s_cfg_gnt) begin
                    if (s_cfg_valid) fin = 1;
                    else begin
                        mb_sent = 1;
                        mb_wait = 0;
                    end
                end
            end else begin
                if (s_cfg_valid) fin = 1;
`ifdef IPA_CFG_ARB_TIMEOUT_EN
                else if (mb_wait == TO - 1) begin
                    fin = 1;
                    timed = 1;
                    mb_terr = 1;
                end else mb_wait++;
`endif
            end
        end
        if (fin) begin
            e_val   = NM'(1) << mb_win;
            e_rd    = timed ? 32'hDEAD_BEEF : s_cfg_rdata;
            e_rid   = mb_id;
            mb_busy = 0;
            mb_ptr  = (mb_win + 1) % NM;
        end
        chk("gnt", m_cfg_gnt, e_gnt);
        chk("valid", m_cfg_valid, e_val);
        chk("rdata", m_cfg_rdata, e_rd);
        chk("r_id", m_cfg_r_id, e_rid);
        chk("s_req", s_cfg_req, e_sreq);
        chk("busy", busy, e_busy);
        if (e_sreq) begin
            chk("s_add", s_cfg_add, mb_add);
            chk("s_wen", s_cfg_wen, mb_wen);
            chk("s_wdata", s_cfg_wdata, mb_wdata);
            chk("s_be", s_cfg_be, mb_be);
            chk("s_id", s_cfg_id, mb_id);
        end
`ifdef IPA_CFG_ARB_TIMEOUT_EN
        chk("timeout_err", timeout_err, e_terr);
`endif
        for (int j = 0; j < NM; j++) begin
            if (m_cfg_gnt[j]) gq.push_back(j);
            if (m_cfg_valid[j]) begin
                vq.push_back(j);
                rq.push_back(int'(m_cfg_r_id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int nreq;
        // Reset: requests present but nothing granted
        rst_n = 0;
        m_cfg_req = 2'b11;
        repeat (2) step();
        @(negedge clk);
        chk("rst_gnt", m_cfg_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sreq", s_cfg_req, 0);
        step();
        rst_n = 1;
        m_cfg_req = 0;
        step();

        // T1: master 0 write with always-grant slave
        set_m(0, 32'h0, 1'b0, 32'h1, 5'd3);
        m_cfg_req = 2'b01;
        @(negedge clk);
        chk("t1_gnt_c0", m_cfg_gnt, 2'b01);
        step();
        m_cfg_req = 0;
        @(negedge clk);
        chk("t1_sreq_c1", s_cfg_req, 1);
        chk("t1_wdata_c1", s_cfg_wdata, 32'h1);
        chk("t1_wen_c1", s_cfg_wen, 0);
        step();
        @(negedge clk);
        chk("t1_valid_c2", m_cfg_valid, 2'b01);
        chk("t1_rid_c2", m_cfg_r_id, 3);
        repeat (3) step();

        // T2: both masters read 0x04 continuously from a zero pointer
        rst_n = 0;
        step();
        rst_n = 1;
        gq.delete(); vq.delete(); rq.delete();
        set_m(0, 32'h4, 1'b1, 32'h0, 5'd7);
        set_m(1, 32'h4, 1'b1, 32'h0, 5'd12);
        m_cfg_req = 2'b11;
        repeat (12) step();
        m_cfg_req = 0;
        chk("t2_ngnt", gq.size(), 4);
        chk("t2_g0", gq[0], 0); chk("t2_g1", gq[1], 1);
        chk("t2_g2", gq[2], 0); chk("t2_g3", gq[3], 1);
        chk("t2_nval", vq.size(), 4);
        chk("t2_v0", vq[0], 0); chk("t2_v1", vq[1], 1);
        chk("t2_r0", rq[0], 7); chk("t2_r1", rq[1], 12);
        chk("t2_r2", rq[2], 7); chk("t2_r3", rq[3], 12);

        // Single requester re-granted back-to-back
        step();
        gq.delete();
        m_cfg_req = 2'b10;
        repeat (6) step();
        m_cfg_req = 0;
        chk("solo_ngnt", gq.size(), 2);
        chk("solo_g0", gq[0], 1);
        chk("solo_g1", gq[1], 1);
        repeat (3) step();

        // T3: slave stalls grant for 3 cycles while master 1 waits
        slv_auto = 0; man_gnt = 0; man_valid = 0;
        set_m(0, 32'h10, 1'b1, 32'h0, 5'd5);
        m_cfg_req = 2'b01;
        @(negedge clk);
        chk("t3_gnt_c0", m_cfg_gnt, 2'b01);
        step();
        set_m(1, 32'h20, 1'b1, 32'h0, 5'd9);
        m_cfg_req = 2'b10;
        nreq = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) man_gnt = 1;
            @(negedge clk);
            if (s_cfg_req) nreq++;
            chk("t3_add_stable", s_cfg_add, 32'h10);
            chk("t3_no_gnt", m_cfg_gnt, 0);
            step();
        end
        man_gnt = 0; man_valid = 1; man_rdata = 32'h1234;
        @(negedge clk);
        chk("t3_req_cycles", nreq, 4);
        chk("t3_valid", m_cfg_valid, 2'b01);
        chk("t3_rdata", m_cfg_rdata, 32'h1234);
        chk("t3_rid", m_cfg_r_id, 5);
        step();
        man_valid = 0; man_rdata = 0; slv_auto = 1;
        @(negedge clk);
        chk("t3_gnt_m1", m_cfg_gnt, 2'b10);
        step();
        m_cfg_req = 0;
        repeat (3) step();

        // Grant and response in the same ISSUE cycle
        slv_auto = 0; man_gnt = 0; man_valid = 0;
        set_m(0, 32'h30, 1'b1, 32'h0, 5'd21);
        m_cfg_req = 2'b01;
        @(negedge clk);
        chk("tq_gnt", m_cfg_gnt, 2'b01);
        step();
        m_cfg_req = 0; man_gnt = 1; man_valid = 1; man_rdata = 32'hCAFE;
        @(negedge clk);
        chk("tq_valid", m_cfg_valid, 2'b01);
        chk("tq_rdata", m_cfg_rdata, 32'hCAFE);
        chk("tq_rid", m_cfg_r_id, 21);
        step();
        man_gnt = 0; man_valid = 0; man_rdata = 0;
        @(negedge clk);
        chk("tq_idle", busy, 0);
        step();

        // T4: reset during RESP, then a stray response
        man_gnt = 1;
        set_m(1, 32'h40, 1'b0, 32'h77, 5'd4);
        m_cfg_req = 2'b10;
        @(negedge clk);
        chk("t4_gnt", m_cfg_gnt, 2'b10);
        step();
        m_cfg_req = 0;
        step();
        rst_n = 0;
        @(negedge clk);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_valid", m_cfg_valid, 0);
        step();
        rst_n = 1; man_valid = 1; man_rdata = 32'hBAD;
        @(negedge clk);
        chk("t4_stray_valid", m_cfg_valid, 0);
        chk("t4_stray_busy", busy, 0);
        step();
        man_valid = 0; man_rdata = 0; slv_auto = 1;
        m_cfg_req = 2'b11;
        @(negedge clk);
        chk("t4_ptr_reset", m_cfg_gnt, 2'b01);
        step();
        m_cfg_req = 0;
        repeat (3) step();

`ifdef IPA_CFG_ARB_TIMEOUT_EN
        // T5: slave never responds
        slv_auto = 0; man_gnt = 1; man_valid = 0;
        set_m(0, 32'h8, 1'b1, 32'h0, 5'd17);
        m_cfg_req = 2'b01;
        @(negedge clk);
        chk("t5_gnt", m_cfg_gnt, 2'b01);
        step();
        m_cfg_req = 0;
        repeat (15) step();
        @(negedge clk);
        chk("t5_no_early", m_cfg_valid, 0);
        step();
        @(negedge clk);
        chk("t5_valid", m_cfg_valid, 2'b01);
        chk("t5_rdata", m_cfg_rdata, 32'hDEAD_BEEF);
        chk("t5_rid", m_cfg_r_id, 17);
        chk("t5_terr_pre", timeout_err, 0);
        step();
        slv_auto = 1;
        set_m(1, 32'hC, 1'b1, 32'h0, 5'd2);
        m_cfg_req = 2'b10;
        @(negedge clk);
        chk("t5_terr_set", timeout_err, 1);
        chk("t5_next_gnt", m_cfg_gnt, 2'b10);
        step();
        m_cfg_req = 0;
        step();
        @(negedge clk);
        chk("t5_next_valid", m_cfg_valid, 2'b10);
        chk("t5_next_rid", m_cfg_r_id, 2);
        chk("t5_terr_sticky", timeout_err, 1);
        step();
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
